rob_recovery_ctrl: RTL and testbench

ROB_RECOVERY_CTRL -- requirements
Module: rob_recovery_ctrl

---
 rtl/sys_defs.sv | 21 ++
 rtl/rob_recovery_ctrl.sv | 107 ++++++++++
 tb/tb_rob_recovery_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared machine-wide definitions: superscalar width, ROB geometry, CDB tag width,
// and the recovery controller's state and rollback packet types.
package sys_defs;

   localparam int unsigned SYS_N_WAY = 2;
   localparam int unsigned SYS_N_ROB = 8;
   localparam int unsigned CDB_BITS  = 6;

   typedef enum logic [1:0] {
      IDLE,
      WALK,
      TRUNC
   } rob_rec_state_e;

   typedef struct packed {
      logic                valid;
      logic [CDB_BITS-1:0] tag;
      logic [CDB_BITS-1:0] told;
   } rollback_packet_t;

endpackage

// File: rtl/rob_recovery_ctrl.sv
// Branch-mispredict recovery: walks the ROB from the tail back to the branch, squashing
// up to N_WAY entries per cycle, then truncates the ROB tail to the branch.
module rob_recovery_ctrl
   import sys_defs::*;
#(
   parameter int unsigned N_WAY    = SYS_N_WAY,
   parameter int unsigned N_ROB    = SYS_N_ROB,
   parameter int unsigned TAG_BITS = CDB_BITS,
   localparam int unsigned IDX_W   = $clog2(N_ROB)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            mispredict_valid,
   input  logic [IDX_W-1:0]                mispredict_idx,
   input  logic [IDX_W-1:0]                rob_head_idx,
   input  logic [IDX_W-1:0]                rob_tail_idx,
   output logic [N_WAY-1:0][IDX_W-1:0]     walk_idx,
   input  logic [N_WAY-1:0][TAG_BITS-1:0]  walk_tag,
   input  logic [N_WAY-1:0][TAG_BITS-1:0]  walk_told,
   output logic [N_WAY-1:0]                rollback_valid,
   output logic [N_WAY-1:0][TAG_BITS-1:0]  rollback_tag,
   output logic [N_WAY-1:0][TAG_BITS-1:0]  rollback_told,
   output logic                            truncate_valid,
   output logic [IDX_W-1:0]                new_tail,
   output logic                            stall_dispatch,
   output logic                            hold_retire,
   output logic                            busy
);

   function automatic logic [IDX_W-1:0] wrap_sub(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
      return a - b;
   endfunction

   rob_rec_state_e   state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] br_q, br_d;
   logic [IDX_W-1:0] rem_q, rem_d;
   logic [IDX_W-1:0] step;
   logic [IDX_W-1:0] ptr_step;
   logic [IDX_W-1:0] mp_dist;
   logic [IDX_W-1:0] br_dist;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         br_q    <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         br_q    <= br_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      br_d     = br_q;
      rem_d    = rem_q;
      step     = (32'(rem_q) < N_WAY) ? rem_q : IDX_W'(N_WAY);
      ptr_step = ptr_q - step;
      mp_dist  = wrap_sub(mispredict_idx, rob_head_idx);
      br_dist  = wrap_sub(br_q, rob_head_idx);

      unique case (state_q)
         IDLE: begin
            if (mispredict_valid) begin
               br_d    = mispredict_idx;
               ptr_d   = rob_tail_idx;
               rem_d   = wrap_sub(wrap_sub(rob_tail_idx, rob_head_idx), mp_dist);
               state_d = (rem_d != '0) ? WALK : TRUNC;
            end
         end
         WALK: begin
            ptr_d = ptr_step;
            rem_d = rem_q - step;
            // An older branch widens the squash range down from where this cycle's walk leaves ptr.
            if (mispredict_valid && (mp_dist < br_dist)) begin
               br_d  = mispredict_idx;
               rem_d = wrap_sub(wrap_sub(ptr_step, rob_head_idx), mp_dist);
            end
            state_d = (rem_d == '0) ? TRUNC : WALK;
         end
         TRUNC: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < int'(N_WAY); i++) begin
         walk_idx[i]       = ptr_q - IDX_W'(i);
         rollback_valid[i] = (state_q == WALK) && (32'(rem_q) > 32'(i));
         rollback_tag[i]   = rollback_valid[i] ? walk_tag[i] : '0;
         rollback_told[i]  = rollback_valid[i] ? walk_told[i] : '0;
      end
   end

   assign truncate_valid = (state_q == TRUNC);
   assign new_tail       = br_q;
   assign busy           = (state_q != IDLE);
   assign stall_dispatch = busy | mispredict_valid;
   assign hold_retire    = busy | mispredict_valid;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Scoreboard bench for rob_recovery_ctrl (N_WAY=2, N_ROB=8): directed mispredict scenarios
// push expected squashes, truncates and per-cycle status; a negedge monitor pops and compares.
module tb_rob_recovery_ctrl;

   logic             clock = 1'b0;
   logic             reset;
   logic             mispredict_valid;
   logic [2:0]       mispredict_idx;
   logic [2:0]       rob_head_idx;
   logic [2:0]       rob_tail_idx;
   logic [1:0][2:0]  walk_idx;
   logic [1:0][5:0]  walk_tag;
   logic [1:0][5:0]  walk_told;
   logic [1:0]       rollback_valid;
   logic [1:0][5:0]  rollback_tag;
   logic [1:0][5:0]  rollback_told;
   logic             truncate_valid;
   logic [2:0]       new_tail;
   logic             stall_dispatch;
   logic             hold_retire;
   logic             busy;

   rob_recovery_ctrl #(
      .N_WAY    (2),
      .N_ROB    (8),
      .TAG_BITS (6)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .mispredict_valid (mispredict_valid),
      .mispredict_idx   (mispredict_idx),
      .rob_head_idx     (rob_head_idx),
      .rob_tail_idx     (rob_tail_idx),
      .walk_idx         (walk_idx),
      .walk_tag         (walk_tag),
      .walk_told        (walk_told),
      .rollback_valid   (rollback_valid),
      .rollback_tag     (rollback_tag),
      .rollback_told    (rollback_told),
      .truncate_valid   (truncate_valid),
      .new_tail         (new_tail),
      .stall_dispatch   (stall_dispatch),
      .hold_retire      (hold_retire),
      .busy             (busy)
   );

   always #5 clock = ~clock;

   // ROB contents: tag of entry k is k, told is k+16.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         walk_tag[i]  = {3'b000, walk_idx[i]};
         walk_told[i] = {3'b010, walk_idx[i]};
      end
   end

   typedef struct {
      int         c;
      logic [2:0] idx;
      logic [5:0] tag;
      logic [5:0] told;
   } rb_exp_t;

   typedef struct {
      int         c;
      logic [2:0] nt;
   } tr_exp_t;

   typedef struct {
      int         c;
      logic       busy;
      logic       stall;
      logic       trunc;
      logic [1:0] rbv;
      logic       chk_w0;
      logic [2:0] w0;
   } st_exp_t;

   rb_exp_t rb_q[$];
   tr_exp_t tr_q[$];
   st_exp_t st_q[$];

   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;
   logic done = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic push_rb(input int c, input logic [2:0] idx, input logic [5:0] tag,
                          input logic [5:0] told);
      rb_q.push_back('{c, idx, tag, told});
   endtask

   task automatic push_tr(input int c, input logic [2:0] nt);
      tr_q.push_back('{c, nt});
   endtask

   task automatic push_st(input int c, input logic b, input logic s, input logic t,
                          input logic [1:0] v);
      st_q.push_back('{c, b, s, t, v, 1'b0, 3'd0});
   endtask

   task automatic push_st_w0(input int c, input logic [2:0] w0);
      st_q.push_back('{c, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, w0});
   endtask

   task automatic step();
      @(posedge clock);
      #3;
   endtask

   task automatic start_mp(input logic [2:0] head, input logic [2:0] tail,
                           input logic [2:0] idx, output int c);
      step();
      rob_head_idx     = head;
      rob_tail_idx     = tail;
      mispredict_valid = 1'b1;
      mispredict_idx   = idx;
      c                = cyc;
   endtask

   // Stimulus
   initial begin
      int c0;
      reset            = 1'b1;
      mispredict_valid = 1'b0;
      mispredict_idx   = '0;
      rob_head_idx     = '0;
      rob_tail_idx     = '0;
      push_st_w0(1, 3'd0);
      push_st(2, 1'b0, 1'b0, 1'b0, 2'b00);
      repeat (3) @(posedge clock);
      #3;
      reset = 1'b0;
      step();

      // Basic walk: head 0, tail 5, branch 2
      start_mp(3'd0, 3'd5, 3'd2, c0);
      push_rb(c0 + 1, 3'd5, 6'd5, 6'd21);
      push_rb(c0 + 1, 3'd4, 6'd4, 6'd20);
      push_rb(c0 + 2, 3'd3, 6'd3, 6'd19);
      push_tr(c0 + 3, 3'd2);
      push_st(c0,     1'b0, 1'b1, 1'b0, 2'b00);
      push_st(c0 + 1, 1'b1, 1'b1, 1'b0, 2'b11);
      push_st(c0 + 2, 1'b1, 1'b1, 1'b0, 2'b01);
      push_st(c0 + 3, 1'b1, 1'b1, 1'b1, 2'b00);
      push_st(c0 + 4, 1'b0, 1'b0, 1'b0, 2'b00);
      step();
      mispredict_valid = 1'b0;
      repeat (5) step();

      // Branch at the tail: straight to truncate
      start_mp(3'd0, 3'd4, 3'd4, c0);
      push_tr(c0 + 1, 3'd4);
      push_st(c0,     1'b0, 1'b1, 1'b0, 2'b00);
      push_st(c0 + 1, 1'b1, 1'b1, 1'b1, 2'b00);
      push_st(c0 + 2, 1'b0, 1'b0, 1'b0, 2'b00);
      step();
      mispredict_valid = 1'b0;
      repeat (3) step();

      // Index wrap: head 6, tail 1, branch 7
      start_mp(3'd6, 3'd1, 3'd7, c0);
      push_rb(c0 + 1, 3'd1, 6'd1, 6'd17);
      push_rb(c0 + 1, 3'd0, 6'd0, 6'd16);
      push_tr(c0 + 2, 3'd7);
      push_st(c0 + 1, 1'b1, 1'b1, 1'b0, 2'b11);
      push_st(c0 + 2, 1'b1, 1'b1, 1'b1, 2'b00);
      push_st(c0 + 3, 1'b0, 1'b0, 1'b0, 2'b00);
      step();
      mispredict_valid = 1'b0;
      repeat (4) step();

      // Nested: older branch 2 arrives mid-walk, younger branch 6 ignored
      start_mp(3'd0, 3'd7, 3'd5, c0);
      push_rb(c0 + 1, 3'd7, 6'd7, 6'd23);
      push_rb(c0 + 1, 3'd6, 6'd6, 6'd22);
      push_rb(c0 + 2, 3'd5, 6'd5, 6'd21);
      push_rb(c0 + 2, 3'd4, 6'd4, 6'd20);
      push_rb(c0 + 3, 3'd3, 6'd3, 6'd19);
      push_tr(c0 + 4, 3'd2);
      push_st(c0 + 1, 1'b1, 1'b1, 1'b0, 2'b11);
      push_st(c0 + 2, 1'b1, 1'b1, 1'b0, 2'b11);
      push_st(c0 + 3, 1'b1, 1'b1, 1'b0, 2'b01);
      push_st(c0 + 4, 1'b1, 1'b1, 1'b1, 2'b00);
      push_st(c0 + 5, 1'b0, 1'b0, 1'b0, 2'b00);
      step();
      mispredict_idx = 3'd2;
      step();
      mispredict_idx = 3'd6;
      step();
      mispredict_valid = 1'b0;
      repeat (4) step();

      // Reset during walk: abort with no truncate
      start_mp(3'd0, 3'd5, 3'd2, c0);
      push_rb(c0 + 1, 3'd5, 6'd5, 6'd21);
      push_rb(c0 + 1, 3'd4, 6'd4, 6'd20);
      push_st(c0 + 1, 1'b1, 1'b1, 1'b0, 2'b11);
      push_st(c0 + 2, 1'b0, 1'b0, 1'b0, 2'b00);
      push_st_w0(c0 + 2, 3'd0);
      push_st(c0 + 3, 1'b0, 1'b0, 1'b0, 2'b00);
      push_st(c0 + 4, 1'b0, 1'b0, 1'b0, 2'b00);
      step();
      mispredict_valid = 1'b0;
      reset            = 1'b1;
      step();
      reset = 1'b0;
      repeat (4) step();

      // Full ROB: head 1, tail 0, branch 1
      start_mp(3'd1, 3'd0, 3'd1, c0);
      push_rb(c0 + 1, 3'd0, 6'd0, 6'd16);
      push_rb(c0 + 1, 3'd7, 6'd7, 6'd23);
      push_rb(c0 + 2, 3'd6, 6'd6, 6'd22);
      push_rb(c0 + 2, 3'd5, 6'd5, 6'd21);
      push_rb(c0 + 3, 3'd4, 6'd4, 6'd20);
      push_rb(c0 + 3, 3'd3, 6'd3, 6'd19);
      push_rb(c0 + 4, 3'd2, 6'd2, 6'd18);
      push_tr(c0 + 5, 3'd1);
      push_st(c0 + 4, 1'b1, 1'b1, 1'b0, 2'b01);
      push_st(c0 + 5, 1'b1, 1'b1, 1'b1, 2'b00);
      push_st(c0 + 6, 1'b0, 1'b0, 1'b0, 2'b00);
      step();
      mispredict_valid = 1'b0;
      repeat (8) step();
      done = 1'b1;
   end

   // Monitor / scoreboard
   initial begin
      rb_exp_t e;
      tr_exp_t t;
      st_exp_t s;
      @(posedge clock);
      forever begin
         @(negedge clock);
         while (rb_q.size() > 0 && rb_q[0].c < cyc) begin
            e = rb_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL rb_missing: cyc %0d got no squash, required idx %0d at cyc %0d",
                     cyc, e.idx, e.c);
         end
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (rollback_valid[i] === 1'b1) begin
               if (rb_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL rb_unexpected lane %0d cyc %0d: got idx %0d, required none",
                           i, cyc, walk_idx[i]);
               end else begin
                  e = rb_q.pop_front();
                  if (e.c != cyc || walk_idx[i] !== e.idx || rollback_tag[i] !== e.tag ||
                      rollback_told[i] !== e.told) begin
                     n_fail++;
                     $display("FAIL rb_lane%0d: got cyc %0d idx %0d tag %0d told %0d, required cyc %0d idx %0d tag %0d told %0d",
                              i, cyc, walk_idx[i], rollback_tag[i], rollback_told[i],
                              e.c, e.idx, e.tag, e.told);
                  end
               end
            end else if (rollback_valid[i] !== 1'b0 || rollback_tag[i] !== 6'd0 ||
                         rollback_told[i] !== 6'd0) begin
               n_fail++;
               $display("FAIL rb_idle_lane%0d cyc %0d: got valid %b tag %0d told %0d, required 0 0 0",
                        i, cyc, rollback_valid[i], rollback_tag[i], rollback_told[i]);
            end
         end

         while (tr_q.size() > 0 && tr_q[0].c < cyc) begin
            t = tr_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL trunc_missing: cyc %0d got none, required new_tail %0d at cyc %0d",
                     cyc, t.nt, t.c);
         end
         if (truncate_valid !== 1'b0) begin
            n_cmp++;
            if (tr_q.size() == 0) begin
               n_fail++;
               $display("FAIL trunc_unexpected cyc %0d: got truncate_valid %b new_tail %0d, required none",
                        cyc, truncate_valid, new_tail);
            end else begin
               t = tr_q.pop_front();
               if (t.c != cyc || new_tail !== t.nt) begin
                  n_fail++;
                  $display("FAIL trunc: got cyc %0d new_tail %0d, required cyc %0d new_tail %0d",
                           cyc, new_tail, t.c, t.nt);
               end
            end
         end

         while (st_q.size() > 0 && st_q[0].c <= cyc) begin
            s = st_q.pop_front();
            n_cmp++;
            if (s.c != cyc) begin
               n_fail++;
               $display("FAIL status_stale: expectation for cyc %0d checked at cyc %0d", s.c, cyc);
            end else if (s.chk_w0) begin
               if (walk_idx[0] !== s.w0) begin
                  n_fail++;
                  $display("FAIL walk_idx0 cyc %0d: got %0d, required %0d", cyc, walk_idx[0], s.w0);
               end
            end else if (busy !== s.busy || stall_dispatch !== s.stall ||
                         hold_retire !== s.stall || truncate_valid !== s.trunc ||
                         rollback_valid !== s.rbv) begin
               n_fail++;
               $display("FAIL status cyc %0d: got busy %b stall %b hold %b trunc %b rbv %b, required busy %b stall %b hold %b trunc %b rbv %b",
                        cyc, busy, stall_dispatch, hold_retire, truncate_valid, rollback_valid,
                        s.busy, s.stall, s.stall, s.trunc, s.rbv);
            end
         end

         if (done) begin
            n_cmp++;
            if (rb_q.size() + tr_q.size() + st_q.size() != 0) begin
               n_fail++;
               $display("FAIL leftover: got %0d unmatched expectations, required 0",
                        rb_q.size() + tr_q.size() + st_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by 100000 time units, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
